// File: rtl/lq_stq_rot_ctl_if.sv
// Requester, rotator and result signals of the load/store rotator control.
// master = controller side, slave = requesters/rotator/consumer side.
interface lq_stq_rot_ctl_if;
    logic       req0_val;
    logic       req0_rdy;
    logic [1:0] req0_off;
    logic [1:0] req0_size;
    logic       req0_se;
    logic [7:0] req0_data;
    logic       req1_val;
    logic       req1_rdy;
    logic [1:0] req1_off;
    logic [1:0] req1_size;
    logic       req1_se;
    logic [7:0] req1_data;
    logic [3:0] rot_sel;
    logic [3:0] rot_mask;
    logic       rot_se_b;
    logic [7:0] rot_data;
    logic [7:0] data_rot;
    logic       res_val;
    logic       res_rdy;
    logic [7:0] res_data;
    logic       res_tag;

    modport master (
        input  req0_val, req0_off, req0_size, req0_se, req0_data,
        input  req1_val, req1_off, req1_size, req1_se, req1_data,
        input  data_rot, res_rdy,
        output req0_rdy, req1_rdy,
        output rot_sel, rot_mask, rot_se_b, rot_data,
        output res_val, res_data, res_tag
    );

    modport slave (
        output req0_val, req0_off, req0_size, req0_se, req0_data,
        output req1_val, req1_off, req1_size, req1_se, req1_data,
        output data_rot, res_rdy,
        input  req0_rdy, req1_rdy,
        input  rot_sel, rot_mask, rot_se_b, rot_data,
        input  res_val, res_data, res_tag
    );
endinterface

// File: rtl/lq_stq_rot_ctl.sv
// Two-requester issue/result pipeline driving an external data rotator.
// Define LQ_STQ_ROT_RR_EN for round-robin arbitration (else req0 priority).
module lq_stq_rot_ctl (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              flush,
    lq_stq_rot_ctl_if.master  io
);

    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       se;
        logic [7:0] data;
        logic       tag;
    } op_t;

    logic       is_val;
    op_t        is_q;
    op_t        op_d;
    logic       rs_val;
    logic [7:0] rs_data;
    logic       rs_tag;
    logic       rs_acc;
    logic       is_adv;
    logic       is_free;
    logic       pick1;
    logic       acc0;
    logic       acc1;

`ifdef LQ_STQ_ROT_RR_EN
    logic gnt_q;

    // gnt_q=1 favours requester 1 when both are valid
    always_comb pick1 = io.req1_val & (~io.req0_val | gnt_q);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            gnt_q <= 1'b0;
        else if (acc0 | acc1)
            gnt_q <= acc0;
    end
`else
    always_comb pick1 = io.req1_val & ~io.req0_val;
`endif

    assign rs_acc  = rs_val & io.res_rdy;
    assign is_adv  = is_val & (~rs_val | io.res_rdy);
    assign is_free = ~is_val | is_adv;
    assign acc0    = rst_b & ~flush & is_free & io.req0_val & ~pick1;
    assign acc1    = rst_b & ~flush & is_free & pick1;

    always_comb begin
        op_d = is_q;
        if (acc1) begin
            op_d.off  = io.req1_off;
            op_d.size = io.req1_size;
            op_d.se   = io.req1_se;
            op_d.data = io.req1_data;
            op_d.tag  = 1'b1;
        end else if (acc0) begin
            op_d.off  = io.req0_off;
            op_d.size = io.req0_size;
            op_d.se   = io.req0_se;
            op_d.data = io.req0_data;
            op_d.tag  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            is_val  <= 1'b0;
            is_q    <= '0;
            rs_val  <= 1'b0;
            rs_data <= 8'h00;
            rs_tag  <= 1'b0;
        end else if (flush) begin
            is_val <= 1'b0;
            rs_val <= 1'b0;
        end else begin
            if (is_adv) begin
                rs_val  <= 1'b1;
                rs_data <= io.data_rot;
                rs_tag  <= is_q.tag;
            end else if (rs_acc) begin
                rs_val <= 1'b0;
            end
            if (acc0 | acc1) begin
                is_val <= 1'b1;
                is_q   <= op_d;
            end else if (is_adv) begin
                is_val <= 1'b0;
            end
        end
    end

    assign io.req0_rdy = acc0;
    assign io.req1_rdy = acc1;
    assign io.rot_sel  = is_val ? (4'b1000 >> is_q.off) : 4'b0000;
    assign io.rot_mask = is_val ? (4'b0001 << is_q.size) : 4'b0000;
    assign io.rot_se_b = ~(is_val & is_q.se);
    assign io.rot_data = is_val ? is_q.data : 8'h00;
    assign io.res_val  = rs_val;
    assign io.res_data = rs_data;
    assign io.res_tag  = rs_tag;

endmodule

// File: tb/tb_lq_stq_rot_ctl.sv
// Bench for lq_stq_rot_ctl with a behavioural rotator and result scoreboard.
// Arbitration expectations follow LQ_STQ_ROT_RR_EN.
module tb_lq_stq_rot_ctl;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic       acc_tag_q[$];

    lq_stq_rot_ctl_if ifc();

    lq_stq_rot_ctl dut (
        .clk   (clk),
        .rst_b (rst_b),
        .flush (flush),
        .io    (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rot_ref(input logic [1:0] off,
                                           input logic [1:0] size,
                                           input logic se,
                                           input logic [7:0] d);
        logic [7:0] s;
        logic [7:0] m;
        int w;
        s = d >> (2 * off);
        w = 1 << size;
        m = 8'((9'd1 << w) - 9'd1);
        s = s & m;
        if (se && s[w-1]) s = s | ~m;
        return s;
    endfunction

    // behavioural rotator fed from the rot_* outputs
    logic [2:0] rm_sh;
    logic [7:0] rm_m;
    logic [7:0] rm_s;
    always_comb begin
        rm_sh = 3'd0;
        if (ifc.rot_sel[2]) rm_sh = 3'd2;
        else if (ifc.rot_sel[1]) rm_sh = 3'd4;
        else if (ifc.rot_sel[0]) rm_sh = 3'd6;
        rm_m = 8'h01;
        if (ifc.rot_mask[3]) rm_m = 8'hFF;
        else if (ifc.rot_mask[2]) rm_m = 8'h0F;
        else if (ifc.rot_mask[1]) rm_m = 8'h03;
        rm_s = (ifc.rot_data >> rm_sh) & rm_m;
        if (!ifc.rot_se_b && (rm_s & ~(rm_m >> 1)) != 8'h00)
            rm_s = rm_s | ~rm_m;
        ifc.data_rot = rm_s;
    end

    always @(negedge clk) begin
        if (!rst_b || flush) begin
            exp_q.delete();
        end else begin
            if (ifc.req0_val && ifc.req0_rdy) begin
                exp_q.push_back({1'b0, rot_ref(ifc.req0_off, ifc.req0_size,
                                               ifc.req0_se, ifc.req0_data)});
                acc_tag_q.push_back(1'b0);
            end
            if (ifc.req1_val && ifc.req1_rdy) begin
                exp_q.push_back({1'b1, rot_ref(ifc.req1_off, ifc.req1_size,
                                               ifc.req1_se, ifc.req1_data)});
                acc_tag_q.push_back(1'b1);
            end
            if (ifc.res_val && ifc.res_rdy)
                obs_q.push_back({ifc.res_tag, ifc.res_data});
        end
    end

    task automatic rnd_reqs();
        ifc.req0_off  = 2'($urandom_range(0, 3));
        ifc.req0_size = 2'($urandom_range(0, 3));
        ifc.req0_se   = 1'($urandom_range(0, 1));
        ifc.req0_data = 8'($urandom_range(0, 255));
        ifc.req1_off  = 2'($urandom_range(0, 3));
        ifc.req1_size = 2'($urandom_range(0, 3));
        ifc.req1_se   = 1'($urandom_range(0, 1));
        ifc.req1_data = 8'($urandom_range(0, 255));
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        acc_tag_q.delete();
    endtask

    task automatic test_reset();
        ifc.req0_val = 1'b1;
        ifc.req1_val = 1'b1;
        ifc.res_rdy  = 1'b1;
        rnd_reqs();
        @(negedge clk);
        n_cmp++;
        if ({ifc.res_val, ifc.req0_rdy, ifc.req1_rdy, ifc.res_tag,
             ifc.rot_se_b} !== 5'b00001) begin
            n_bad++;
            $display("FAIL rst_ctl: got %b want 00001",
                     {ifc.res_val, ifc.req0_rdy, ifc.req1_rdy,
                      ifc.res_tag, ifc.rot_se_b});
        end
        n_cmp++;
        if ({ifc.rot_sel, ifc.rot_mask} !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_selmask: got %h want 00",
                     {ifc.rot_sel, ifc.rot_mask});
        end
        n_cmp++;
        if ({ifc.rot_data, ifc.res_data} !== 16'h0000) begin
            n_bad++;
            $display("FAIL rst_data: got %h want 0000",
                     {ifc.rot_data, ifc.res_data});
        end
        ifc.req0_val = 1'b0;
        ifc.req1_val = 1'b0;
        #2 rst_b = 1'b1;
        clear_sb();
    endtask

    task automatic test_arb();
        logic [3:0] got;
        logic [3:0] want;
        logic [8:0] o;
        logic [8:0] e;
`ifdef LQ_STQ_ROT_RR_EN
        want = 4'b0101;
`else
        want = 4'b0000;
`endif
        clear_sb();
        ifc.res_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rnd_reqs();
            ifc.req0_val = 1'b1;
            ifc.req1_val = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ($countones({ifc.req0_rdy, ifc.req1_rdy}) != 1) begin
                n_bad++;
                $display("FAIL arb_onehot: got %b want one grant",
                         {ifc.req0_rdy, ifc.req1_rdy});
            end
        end
        @(posedge clk); #1;
        ifc.req0_val = 1'b0;
        ifc.req1_val = 1'b0;
        got = 4'b0;
        n_cmp++;
        if (acc_tag_q.size() != 4) begin
            n_bad++;
            $display("FAIL arb_accepts: got %0d want 4", acc_tag_q.size());
        end
        while (acc_tag_q.size() > 0) got = {got[2:0], acc_tag_q.pop_front()};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL arb_tags: got %b want %b", got, want);
        end
        for (int i = 0; i < 20 && obs_q.size() < 4; i++) begin
            @(negedge clk); #1;
        end
        n_cmp++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            n_bad++;
            $display("FAIL arb_count: got %0d/%0d want 4",
                     obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL arb_result: got %h want %h", o, e);
            end
        end
        clear_sb();
    endtask

    task automatic test_single();
        logic [8:0] o;
        logic [8:0] e;
        clear_sb();
        ifc.res_rdy = 1'b1;
        @(posedge clk); #1;
        ifc.req0_val  = 1'b1;
        ifc.req0_off  = 2'd1;
        ifc.req0_size = 2'd2;
        ifc.req0_se   = 1'b0;
        ifc.req0_data = 8'hB4;
        @(negedge clk);
        n_cmp++;
        if (ifc.req0_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_rdy: got %b want 1", ifc.req0_rdy);
        end
        @(posedge clk); #1;
        ifc.req0_val = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ifc.rot_sel, ifc.rot_mask, ifc.rot_se_b, ifc.rot_data,
             ifc.res_val} !== {8'b01000100, 1'b1, 8'hB4, 1'b0}) begin
            n_bad++;
            $display("FAIL single_issue: got %b_%b_%b_%h_%b want 0100_0100_1_b4_0",
                     ifc.rot_sel, ifc.rot_mask, ifc.rot_se_b,
                     ifc.rot_data, ifc.res_val);
        end
        @(negedge clk);
        n_cmp++;
        if ({ifc.res_val, ifc.res_tag, ifc.res_data} !== 10'b1_0_00001101) begin
            n_bad++;
            $display("FAIL single_res: got %b_%b_%h want 1_0_0d",
                     ifc.res_val, ifc.res_tag, ifc.res_data);
        end
        #1;
        n_cmp++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++;
            $display("FAIL single_count: got %0d/%0d want 1",
                     obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL single_sb: got %h want %h", o, e);
            end
        end
        clear_sb();
    endtask

    task automatic test_sign_ext();
        logic [8:0] o;
        logic [8:0] e;
        clear_sb();
        ifc.res_rdy = 1'b1;
        @(posedge clk); #1;
        ifc.req1_val  = 1'b1;
        ifc.req1_off  = 2'd0;
        ifc.req1_size = 2'd3;
        ifc.req1_se   = 1'b1;
        ifc.req1_data = 8'h5A;
        @(posedge clk); #1;
        ifc.req1_off  = 2'd2;
        ifc.req1_size = 2'd1;
        ifc.req1_se   = 1'b1;
        ifc.req1_data = 8'h30;
        @(negedge clk);
        n_cmp++;
        if ({ifc.rot_se_b, ifc.rot_data} !== 9'b0_01011010) begin
            n_bad++;
            $display("FAIL se_issue: got %b_%h want 0_5a",
                     ifc.rot_se_b, ifc.rot_data);
        end
        @(posedge clk); #1;
        ifc.req1_val = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ifc.res_val, ifc.res_tag, ifc.res_data} !== 10'b1_1_01011010) begin
            n_bad++;
            $display("FAIL se_res: got %b_%b_%h want 1_1_5a",
                     ifc.res_val, ifc.res_tag, ifc.res_data);
        end
        @(negedge clk);
        n_cmp++;
        if ({ifc.res_val, ifc.res_tag, ifc.res_data} !== 10'b1_1_11111111) begin
            n_bad++;
            $display("FAIL se_neg: got %b_%b_%h want 1_1_ff",
                     ifc.res_val, ifc.res_tag, ifc.res_data);
        end
        #1;
        n_cmp++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_bad++;
            $display("FAIL se_count: got %0d/%0d want 2",
                     obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL se_sb: got %h want %h", o, e);
            end
        end
        clear_sb();
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        logic [8:0] o;
        logic [8:0] e;
        clear_sb();
        held = 8'h00;
        @(posedge clk); #1;
        ifc.res_rdy  = 1'b0;
        ifc.req0_val = 1'b1;
        ifc.req1_val = 1'b1;
        rnd_reqs();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                n_cmp++;
                if ({ifc.req0_rdy, ifc.req1_rdy, ifc.res_val} !== 3'b001) begin
                    n_bad++;
                    $display("FAIL bp_full: got %b want 001",
                             {ifc.req0_rdy, ifc.req1_rdy, ifc.res_val});
                end
            end
            if (c == 2) held = ifc.res_data;
            if (c == 3) begin
                n_cmp++;
                if (ifc.res_data !== held) begin
                    n_bad++;
                    $display("FAIL bp_hold: got %h want %h",
                             ifc.res_data, held);
                end
            end
            @(posedge clk); #1;
            rnd_reqs();
        end
        ifc.req0_val = 1'b0;
        ifc.req1_val = 1'b0;
        n_cmp++;
        if (acc_tag_q.size() != 2) begin
            n_bad++;
            $display("FAIL bp_accepts: got %0d want 2", acc_tag_q.size());
        end
        ifc.res_rdy = 1'b1;
        for (int i = 0; i < 20 && obs_q.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_bad++;
            $display("FAIL bp_count: got %0d/%0d want 2",
                     obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL bp_sb: got %h want %h", o, e);
            end
        end
        clear_sb();
    endtask

    task automatic test_flush();
        logic [8:0] o;
        logic [8:0] e;
        clear_sb();
        @(posedge clk); #1;
        ifc.res_rdy  = 1'b0;
        ifc.req0_val = 1'b1;
        rnd_reqs();
        @(posedge clk); #1;
        rnd_reqs();
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ifc.req0_rdy, ifc.req1_rdy, ifc.res_val} !== 3'b001) begin
            n_bad++;
            $display("FAIL flush_rdy: got %b want 001",
                     {ifc.req0_rdy, ifc.req1_rdy, ifc.res_val});
        end
        @(posedge clk); #1;
        flush = 1'b0;
        ifc.req0_val = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ifc.res_val, ifc.rot_sel, ifc.rot_se_b} !== 6'b0_0000_1) begin
            n_bad++;
            $display("FAIL flush_empty: got %b_%b_%b want 0_0000_1",
                     ifc.res_val, ifc.rot_sel, ifc.rot_se_b);
        end
        clear_sb();
        @(posedge clk); #1;
        ifc.res_rdy   = 1'b1;
        ifc.req0_val  = 1'b1;
        ifc.req0_off  = 2'd3;
        ifc.req0_size = 2'd0;
        ifc.req0_se   = 1'b1;
        ifc.req0_data = 8'hC0;
        @(posedge clk); #1;
        ifc.req0_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ifc.res_val, ifc.res_tag, ifc.res_data} !== 10'b1_0_11111111) begin
            n_bad++;
            $display("FAIL flush_next: got %b_%b_%h want 1_0_ff",
                     ifc.res_val, ifc.res_tag, ifc.res_data);
        end
        #1;
        n_cmp++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++;
            $display("FAIL flush_count: got %0d/%0d want 1",
                     obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL flush_sb: got %h want %h", o, e);
            end
        end
        clear_sb();
    endtask

    task automatic test_reset_mid();
        logic [8:0] o;
        logic [8:0] e;
        clear_sb();
        @(posedge clk); #1;
        ifc.res_rdy  = 1'b1;
        ifc.req0_val = 1'b1;
        ifc.req1_val = 1'b1;
        rnd_reqs();
        @(posedge clk); #1;
        rnd_reqs();
        @(posedge clk); #1;
        #2 rst_b = 1'b0;
        #1;
        n_cmp++;
        if ({ifc.res_val, ifc.req0_rdy, ifc.req1_rdy, ifc.res_tag,
             ifc.rot_se_b} !== 5'b00001) begin
            n_bad++;
            $display("FAIL rmid_ctl: got %b want 00001",
                     {ifc.res_val, ifc.req0_rdy, ifc.req1_rdy,
                      ifc.res_tag, ifc.rot_se_b});
        end
        n_cmp++;
        if ({ifc.rot_sel, ifc.rot_mask, ifc.rot_data, ifc.res_data} !== 24'h0) begin
            n_bad++;
            $display("FAIL rmid_data: got %h want 000000",
                     {ifc.rot_sel, ifc.rot_mask, ifc.rot_data, ifc.res_data});
        end
        ifc.req0_val = 1'b0;
        ifc.req1_val = 1'b0;
        @(negedge clk);
        #2 rst_b = 1'b1;
        clear_sb();
        @(posedge clk); #1;
        rnd_reqs();
        ifc.req0_val = 1'b1;
        ifc.req1_val = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ifc.req0_rdy, ifc.req1_rdy} !== 2'b10) begin
            n_bad++;
            $display("FAIL rmid_first: got %b want 10",
                     {ifc.req0_rdy, ifc.req1_rdy});
        end
        @(posedge clk); #1;
        ifc.req0_val = 1'b0;
        ifc.req1_val = 1'b0;
        for (int i = 0; i < 20 && obs_q.size() < 1; i++) begin
            @(negedge clk); #1;
        end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++;
            $display("FAIL rmid_count: got %0d/%0d want 1",
                     obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rmid_sb: got %h want %h", o, e);
            end
        end
        clear_sb();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        ifc.req0_val  = 1'b0;
        ifc.req1_val  = 1'b0;
        ifc.req0_off  = 2'd0;
        ifc.req0_size = 2'd0;
        ifc.req0_se   = 1'b0;
        ifc.req0_data = 8'h00;
        ifc.req1_off  = 2'd0;
        ifc.req1_size = 2'd0;
        ifc.req1_se   = 1'b0;
        ifc.req1_data = 8'h00;
        ifc.res_rdy   = 1'b1;
        test_reset();
        test_arb();
        test_single();
        test_sign_ext();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lq_stq_rot_ctl.md
LQ_STQ_ROT_CTL -- requirements
Module: lq_stq_rot_ctl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_b  in  1  asynchronous, active-low reset.
REQ-003 flush  in  1  synchronous discard of all in-flight work.
REQ-004 req0_val / req1_val  in  1 each  requester 0/1 has an operation.
REQ-005 req0_rdy / req1_rdy  out  1 each  operation accepted this cycle when val&rdy.
REQ-006 reqN_off  in  2  lane offset; shift right by 2*off bits.
REQ-007 reqN_size  in  2  field size: 0=1 bit, 1=2 bits, 2=4 bits, 3=8 bits.
REQ-008 reqN_se  in  1  sign-extend request.
REQ-009 reqN_data  in  8  unrotated data.
REQ-010 rot_sel  out  4  one-hot shift select to rotator.
REQ-011 rot_mask  out  4  size mask to rotator.
REQ-012 rot_se_b  out  1  active-low sign-extend to rotator.
REQ-013 rot_data  out  8  data to rotator.
REQ-014 data_rot  in  8  rotator result (combinational from rot_* outputs).
REQ-015 res_val  out  1  result valid; res_rdy  in  1  consumer accepts.
REQ-016 res_data  out  8  rotated result; res_tag  out  1  originating requester.

Function
REQ-017 Two-stage pipeline: issue register (IS) drives rot_* outputs; result register (RS) captures data_rot, tag.
REQ-018 rot_sel = one-hot of off: off 0->1000, 1->0100, 2->0010, 3->0001.
REQ-019 rot_mask = one-hot of size: size 3->1000, 2->0100, 1->0010, 0->0001.
REQ-020 rot_se_b = ~se; rot_data = registered data.
REQ-021 When IS is empty, rot_sel, rot_mask, rot_data drive 0 and rot_se_b drives 1.
REQ-022 IS advances into RS when RS is empty or RS is accepted (res_val&res_rdy) in the same cycle.
REQ-023 IS accepts a new request when empty or advancing in the same cycle.
REQ-024 At most one rdy asserts per cycle, and only to a requester with val=1.
REQ-025 Arbitration: round-robin; the grant pointer toggles to the other requester after each accepted operation; with one requester valid, that requester wins.
REQ-026 Latency: accepted at edge N -> res_val=1 after edge N+1 with no backpressure.
REQ-027 Throughput: one operation per cycle with res_rdy held at 1.
REQ-028 RS holds res_data and res_tag stable while res_val=1 and res_rdy=0.
REQ-029 Full (IS and RS valid, res_rdy=0): both rdy=0; no state changes.
REQ-030 Simultaneous RS accept and IS advance and new accept in one cycle: all three occur, with no bubble.
REQ-031 flush=1: IS and RS are invalidated at the next edge, both rdy=0 that cycle, the grant pointer is unchanged, and flush overrides all other events.
REQ-032 req*_rdy depends only on registered state, flush and val (no combinational path from res_rdy to req_rdy beyond REQ-022/023).

Reset
REQ-033 rst_b=0 asynchronously clears IS/RS valid, data and tag to 0 and sets the grant pointer to requester 0.
REQ-034 During reset: res_val=0, rdy=0, res_data=0, res_tag=0, rot_se_b=1, other rot_* outputs 0.
REQ-035 Reset asserted mid-operation drops in-flight results; there is no partial output after release.

Configuration
REQ-036 Macro LQ_STQ_ROT_RR_EN: when defined, arbitration is round-robin per REQ-025.
REQ-037 Without LQ_STQ_ROT_RR_EN, arbitration is fixed priority (requester 0 always wins) and the grant pointer is not implemented.

Verification
REQ-038 req0 off=1 size=2 se=0 data=0xB4, res_rdy=1 -> rot_sel=0100 and rot_mask=0100 after edge 1; res_data=0x0D, tag=0 after edge 2.
REQ-039 req1 off=0 size=3 se=1 data=0x5A -> res_data=0x5A, tag=1, rot_se_b=0 during issue.
REQ-040 Both valid for 4 cycles, res_rdy=1, RR_EN defined -> tags 0,1,0,1; without the macro -> 0,0,0,0.
REQ-041 res_rdy=0 for 3 cycles with both valid -> one accept to fill IS, one to fill RS, then rdy=0; res_data stable; after res_rdy=1, results drain in order with no loss or duplicate.
REQ-042 flush with IS and RS both valid -> res_val=0 next cycle; next accepted op returns on schedule.
REQ-043 rst_b pulsed low mid-stream between edges -> outputs per REQ-034 immediately; after release the first request goes to requester 0 when both are valid.
